// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide unit for the execute stage.
// Define EX_MULDIV_FAST_MUL_EN to compute multiplies in a single cycle at accept.
module ex_muldiv #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = $clog2(DWIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        func,
    input  logic [DWIDTH-1:0] data_rs1,
    input  logic [DWIDTH-1:0] data_rs2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic              stall
);
    localparam int W = DWIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               state_q;
    logic [2:0]           func_q;
    logic [W-1:0]         a_q, b_q, result_q;
    logic [2*W-1:0]       acc_q;
    logic                 neg_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Operand decode: magnitudes and result sign for the request on the inputs.
    logic         is_div, is_rem, is_sdiv, a_signed, b_signed, a_neg, b_neg, res_neg;
    logic         div_zero, div_ovf;
    logic [W-1:0] a_mag, b_mag, special_res;

    assign is_div   = func[2];
    assign is_rem   = func[2] & func[1];
    assign is_sdiv  = func[2] & ~func[0];
    assign a_signed = (func == 3'b001) | (func == 3'b010) | is_sdiv;
    assign b_signed = (func == 3'b001) | is_sdiv;
    assign a_neg    = a_signed & data_rs1[W-1];
    assign b_neg    = b_signed & data_rs2[W-1];
    assign a_mag    = a_neg ? -data_rs1 : data_rs1;
    assign b_mag    = b_neg ? -data_rs2 : data_rs2;
    assign res_neg  = is_rem ? a_neg : (a_neg ^ b_neg);

    assign div_zero    = is_div & (data_rs2 == '0);
    assign div_ovf     = is_sdiv & (data_rs1 == MOST_NEG) & (data_rs2 == '1);
    assign special_res = div_zero ? (is_rem ? data_rs1 : '1)
                                  : (is_rem ? '0 : MOST_NEG);

`ifdef EX_MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_raw, fast_prod;
    logic [W-1:0]   fast_res;
    assign fast_raw  = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
    assign fast_prod = res_neg ? -fast_raw : fast_raw;
    assign fast_res  = (func[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`endif

    // One iteration: shift-add multiply (acc = {partial, multiplier}) or
    // restoring divide (acc = {remainder, dividend/quotient}).
    logic [W:0]     mul_sum, div_sh, div_diff;
    logic           div_ge;
    logic [2*W-1:0] mul_next, div_next, step_next, mul_prod;
    logic [W-1:0]   mul_res, div_val, div_res, final_res;

    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? a_q : {W{1'b0}})};
    assign mul_next  = {mul_sum, acc_q[W-1:1]};
    assign div_sh    = acc_q[2*W-1:W-1];
    assign div_diff  = div_sh - {1'b0, b_q};
    assign div_ge    = ~div_diff[W];
    assign div_next  = {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]), acc_q[W-2:0], div_ge};
    assign step_next = func_q[2] ? div_next : mul_next;

    assign mul_prod  = neg_q ? -mul_next : mul_next;
    assign mul_res   = (func_q[1:0] == 2'b00) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];
    assign div_val   = func_q[1] ? div_next[2*W-1:W] : div_next[W-1:0];
    assign div_res   = neg_q ? -div_val : div_val;
    assign final_res = func_q[2] ? div_res : mul_res;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Flush wins over a simultaneous request.
                    if (in_valid && !flush) begin
                        func_q <= func;
                        a_q    <= a_mag;
                        b_q    <= b_mag;
                        neg_q  <= res_neg;
                        cnt_q  <= '0;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state_q  <= S_DONE;
                        end
`ifdef EX_MULDIV_FAST_MUL_EN
                        else if (!func[2]) begin
                            result_q <= fast_res;
                            state_q  <= S_DONE;
                        end
`endif
                        else begin
                            acc_q   <= {{W{1'b0}}, (func[2] ? a_mag : b_mag)};
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= step_next;
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(W - 1)) begin
                            result_q <= final_res;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign stall     = (state_q == S_BUSY) | ((state_q == S_DONE) & ~out_ready)
                     | (in_valid & in_ready);

endmodule
